// File: rtl/spectrum_pkg.sv
// Shared types for the spectrum frame controller.
// Holds the FSM encoding and the bin-word field layout.
package spectrum_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_DRAIN,
    ST_DONE
  } state_e;

  localparam int X_HI = 31;
  localparam int X_LO = 16;
  localparam int Y_HI = 15;
  localparam int Y_LO = 0;

  function automatic logic signed [15:0] bin_x(
    input logic [31:0] w
  );
    return w[X_HI:X_LO];
  endfunction

  function automatic logic signed [15:0] bin_y(
    input logic [31:0] w
  );
    return w[Y_HI:Y_LO];
  endfunction

endpackage

// File: rtl/log_mag_calc.sv
// Log2 magnitude of one bin: {msb index, two mantissa bits}.
// Zero and one both map to 0.
module log_mag_calc
  import spectrum_pkg::*;
(
  input  logic [31:0] bin_word,
  output logic [7:0]  log_mag
);

  logic signed [15:0] x;
  logic signed [15:0] y;
  logic signed [31:0] xx;
  logic signed [31:0] yy;
  logic [32:0] mag;
  logic [32:0] norm;
  logic [5:0]  msb;

  assign x  = bin_x(bin_word);
  assign y  = bin_y(bin_word);
  assign xx = 32'(x) * 32'(x);
  assign yy = 32'(y) * 32'(y);
  assign mag = {1'b0, xx} + {1'b0, yy};

  always_comb begin
    msb = '0;
    for (int i = 0; i < 33; i++) begin
      if (mag[i]) msb = 6'(i);
    end
  end

  // Left-justify so the two bits under the MSB land at [31:30].
  assign norm = mag << (6'd32 - msb);
  assign log_mag = {msb, norm[31:30]};

endmodule

// File: rtl/spectrum_frame_ctrl.sv
// Frame controller: reads FFT bins, writes log magnitudes,
// tracks the per-frame peak and counts completed frames.
module spectrum_frame_ctrl
  import spectrum_pkg::*;
#(
  parameter int N_BINS = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [31:0]       rd_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy,
  output logic              done,
  output logic [7:0]        peak_val,
  output logic [ADDR_W-1:0] peak_bin,
  output logic [15:0]       frame_cnt
);

  state_e state_q, state_d;

  logic [ADDR_W-1:0] addr_q;
  logic              drain_q;
  logic              last_addr;
  logic              enter_read;
  logic              enter_done;

  logic              s1_valid;
  logic [ADDR_W-1:0] s1_addr;
  logic              s2_valid;
  logic [ADDR_W-1:0] s2_addr;
  logic [7:0]        s2_data;
  logic [7:0]        lm;

  logic [7:0]        run_val;
  logic [ADDR_W-1:0] run_bin;
  logic              s2_wins;
  logic [7:0]        cur_val;
  logic [ADDR_W-1:0] cur_bin;

  logic [7:0]        peak_val_q;
  logic [ADDR_W-1:0] peak_bin_q;
  logic [15:0]       frame_cnt_q;

  assign last_addr = addr_q == ADDR_W'(N_BINS - 1);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start && !abort) state_d = ST_READ;
      ST_READ: begin
        if (abort)          state_d = ST_IDLE;
        else if (last_addr) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (abort)        state_d = ST_IDLE;
        else if (drain_q) state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
    endcase
  end

  assign enter_read = (state_q == ST_IDLE) && (state_d == ST_READ);
  assign enter_done = (state_q == ST_DRAIN) && (state_d == ST_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      drain_q <= 1'b0;
    end else begin
      state_q <= state_d;
      drain_q <= (state_q == ST_DRAIN) && (state_d == ST_DRAIN);
      if ((state_q == ST_READ) && !abort && !last_addr)
        addr_q <= addr_q + 1'b1;
      else
        addr_q <= '0;
    end
  end

  log_mag_calc u_log (
    .bin_word (rd_data),
    .log_mag  (lm)
  );

  // The RAM presents rd_data registered, so stage 1 is the tag that
  // accompanies it; stage 2 captures the log value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_addr  <= '0;
      s2_valid <= 1'b0;
      s2_addr  <= '0;
      s2_data  <= '0;
    end else begin
      s1_valid <= rd_en && !abort;
      s1_addr  <= rd_addr;
      s2_valid <= s1_valid && !abort;
      s2_addr  <= s1_addr;
      s2_data  <= lm;
    end
  end

  // Writes arrive in ascending order, so strict > keeps the lower bin.
  assign s2_wins = s2_valid && (s2_data > run_val);
  assign cur_val = s2_wins ? s2_data : run_val;
  assign cur_bin = s2_wins ? s2_addr : run_bin;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_val     <= '0;
      run_bin     <= '0;
      peak_val_q  <= '0;
      peak_bin_q  <= '0;
      frame_cnt_q <= '0;
    end else begin
      if (enter_read) begin
        run_val <= '0;
        run_bin <= '0;
      end else if (s2_wins) begin
        run_val <= s2_data;
        run_bin <= s2_addr;
      end
      if (enter_done) begin
        peak_val_q  <= cur_val;
        peak_bin_q  <= cur_bin;
        frame_cnt_q <= frame_cnt_q + 16'd1;
      end
    end
  end

  assign rd_en     = state_q == ST_READ;
  assign rd_addr   = addr_q;
  assign wr_en     = s2_valid;
  assign wr_addr   = s2_addr;
  assign wr_data   = s2_data;
  assign busy      = (state_q == ST_READ) || (state_q == ST_DRAIN);
  assign done      = state_q == ST_DONE;
  assign peak_val  = peak_val_q;
  assign peak_bin  = peak_bin_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_spectrum_frame_ctrl.sv
// Scoreboard bench for spectrum_frame_ctrl with N_BINS=4.
// Stimulus pushes expected writes/done; a monitor pops and compares.
module tb_spectrum_frame_ctrl;

  localparam int N  = 4;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          abort;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [31:0]   rd_data = '0;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          busy;
  logic          done;
  logic [7:0]    peak_val;
  logic [AW-1:0] peak_bin;
  logic [15:0]   frame_cnt;

  spectrum_frame_ctrl #(.N_BINS(N), .ADDR_W(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy),
    .done      (done),
    .peak_val  (peak_val),
    .peak_bin  (peak_bin),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [N];
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Bin words and hand-computed log values {msb, 2 bits below msb}.
  logic [31:0] fr [3][N] = '{
    '{32'h0001_0000, 32'h0002_0000, 32'h0004_0000, 32'h0008_0000},
    '{32'h0003_0000, 32'h0064_0000, 32'h0000_FFFB, 32'h0000_0064},
    '{32'h0003_0004, 32'h8000_8000, 32'h0000_0000, 32'h0007_0000}
  };
  logic [7:0] ex [3][N] = '{
    '{8'd0,  8'd8,   8'd16, 8'd24},
    '{8'd12, 8'd52,  8'd18, 8'd52},
    '{8'd18, 8'd124, 8'd0,  8'd22}
  };
  logic [7:0]    pk_v [3] = '{8'd24, 8'd52, 8'd124};
  logic [AW-1:0] pk_b [3] = '{2'd3, 2'd1, 2'd1};

  typedef struct {
    int          cyc;
    logic [AW-1:0] addr;
    logic [7:0]  data;
  } wr_t;

  typedef struct {
    int            cyc;
    logic [7:0]    val;
    logic [AW-1:0] bin;
    logic [15:0]   cnt;
  } dn_t;

  wr_t wq[$];
  dn_t dq[$];
  wr_t w;
  dn_t d;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [15:0]   exp_cnt = '0;
  logic [7:0]    hold_v  = '0;
  logic [AW-1:0] hold_b  = '0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)",
               name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (wr_en) begin
      if (wq.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_wr: addr %0d data %0d at cyc %0d",
                 wr_addr, wr_data, cyc);
      end else begin
        w = wq.pop_front();
        chk("wr_cyc",  32'(cyc),     32'(w.cyc));
        chk("wr_addr", 32'(wr_addr), 32'(w.addr));
        chk("wr_data", 32'(wr_data), 32'(w.data));
      end
    end
    if (done) begin
      if (dq.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_done: at cyc %0d", cyc);
      end else begin
        d = dq.pop_front();
        chk("done_cyc",  32'(cyc),       32'(d.cyc));
        chk("peak_val",  32'(peak_val),  32'(d.val));
        chk("peak_bin",  32'(peak_bin),  32'(d.bin));
        chk("frame_cnt", 32'(frame_cnt), 32'(d.cnt));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_rd_en"},     32'(rd_en),     32'd0);
    chk({tag, "_rd_addr"},   32'(rd_addr),   32'd0);
    chk({tag, "_wr_en"},     32'(wr_en),     32'd0);
    chk({tag, "_wr_addr"},   32'(wr_addr),   32'd0);
    chk({tag, "_wr_data"},   32'(wr_data),   32'd0);
    chk({tag, "_busy"},      32'(busy),      32'd0);
    chk({tag, "_done"},      32'(done),      32'd0);
    chk({tag, "_peak_val"},  32'(peak_val),  32'd0);
    chk({tag, "_peak_bin"},  32'(peak_bin),  32'd0);
    chk({tag, "_frame_cnt"}, 32'(frame_cnt), 32'd0);
  endtask

  // abort_at < 0 runs to completion; otherwise abort is driven at
  // relative cycle abort_at (start sampled at the end of cycle 0).
  task automatic run_frame(input int f, input int abort_at,
                           input bit start_in_read,
                           input bit start_on_done);
    int c;
    int n_wr;
    for (int i = 0; i < N; i++) mem[i] = fr[f][i];
    c = cyc;
    n_wr = (abort_at < 0) ? N : abort_at - 2;
    for (int i = 0; i < n_wr; i++)
      wq.push_back('{cyc: c + 3 + i, addr: AW'(i), data: ex[f][i]});
    if (abort_at < 0) begin
      exp_cnt = exp_cnt + 16'd1;
      hold_v  = pk_v[f];
      hold_b  = pk_b[f];
      dq.push_back('{cyc: c + N + 3, val: pk_v[f], bin: pk_b[f],
                     cnt: exp_cnt});
    end
    start = 1'b1;
    for (int k = 1; k <= N + 5; k++) begin
      step();
      start = (start_in_read && k == 2) || (start_on_done && k == N + 3);
      abort = (k == abort_at);
      if (k == 1) begin
        chk("busy_read",  32'(busy),    32'd1);
        chk("rd_en_read", 32'(rd_en),   32'd1);
        chk("rd_addr0",   32'(rd_addr), 32'd0);
      end
      if (abort_at > 0 && k == abort_at + 1) begin
        chk("abort_busy",  32'(busy),      32'd0);
        chk("abort_pval",  32'(peak_val),  32'(hold_v));
        chk("abort_pbin",  32'(peak_bin),  32'(hold_b));
        chk("abort_fcnt",  32'(frame_cnt), 32'(exp_cnt));
      end
    end
    start = 1'b0;
    abort = 1'b0;
    repeat (4) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    for (int i = 0; i < N; i++) mem[i] = '0;
    repeat (3) step();
    check_idle_outputs("reset");
    rst_n = 1'b1;
    repeat (2) step();

    run_frame(0, -1, 1'b1, 1'b0);
    run_frame(1, -1, 1'b0, 1'b1);
    run_frame(2, 3, 1'b0, 1'b0);

    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    step();
    chk("start_abort_idle", 32'(busy), 32'd0);
    repeat (4) step();

    run_frame(2, -1, 1'b0, 1'b0);

    force dut.frame_cnt_q = 16'hFFFF;
    #1;
    release dut.frame_cnt_q;
    exp_cnt = 16'hFFFF;
    step();
    chk("cnt_preset", 32'(frame_cnt), 32'h0000_FFFF);
    run_frame(0, -1, 1'b0, 1'b0);

    for (int i = 0; i < N; i++) mem[i] = fr[0][i];
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    #1;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("midrst");
    wq.delete();
    dq.delete();
    exp_cnt = '0;
    hold_v  = '0;
    hold_b  = '0;
    step();
    rst_n = 1'b1;
    repeat (6) step();
    chk("post_rst_busy", 32'(busy), 32'd0);

    run_frame(0, -1, 1'b0, 1'b0);

    chk("wq_empty", 32'(wq.size()), 32'd0);
    chk("dq_empty", 32'(dq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/spectrum_frame_ctrl.md
SPECTRUM_FRAME_CTRL -- requirements
Module: spectrum_frame_ctrl

Interface
REQ-001 SHALL have parameter N_BINS, default 256, number of FFT bins per frame (power of two, 4..4096).
REQ-002 SHALL have parameter ADDR_W, default 8, equal to log2(N_BINS).
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port start  input  1  one-cycle frame request.
REQ-006 SHALL have port abort  input  1  cancel frame in progress.
REQ-007 SHALL have port rd_en  output  1  bin RAM read strobe.
REQ-008 SHALL have port rd_addr  output  ADDR_W  bin RAM read address.
REQ-009 SHALL have port rd_data  input  32  bin word {x[31:16], y[15:0]}, signed two's complement, valid one cycle after rd_en.
REQ-010 SHALL have port wr_en  output  1  display column RAM write strobe.
REQ-011 SHALL have port wr_addr  output  ADDR_W  display column write address.
REQ-012 SHALL have port wr_data  output  8  log-magnitude value.
REQ-013 SHALL have port busy  output  1  frame in progress.
REQ-014 SHALL have port done  output  1  one-cycle frame-complete pulse.
REQ-015 SHALL have port peak_val  output  8  largest wr_data of last completed frame.
REQ-016 SHALL have port peak_bin  output  ADDR_W  bin index of peak_val.
REQ-017 SHALL have port frame_cnt  output  16  completed-frame count.

Function
REQ-018 SHALL implement states IDLE, READ, DRAIN, DONE.
REQ-019 IDLE->READ when start=1 and abort=0; start in any other state SHALL be ignored.
REQ-020 READ: rd_en=1, rd_addr=0..N_BINS-1, one address per cycle; after address N_BINS-1 SHALL go to DRAIN.
REQ-021 DRAIN SHALL last exactly 2 cycles, then go to DONE; DONE SHALL last 1 cycle, then go to IDLE.
REQ-022 Pipeline: rd_data registered into stage 1; log magnitude of stage 1 registered into stage 2; wr_en/wr_addr/wr_data driven from stage 2.
REQ-023 Bin read at cycle t SHALL be written at cycle t+2 with wr_addr equal to its rd_addr.
REQ-024 With start sampled at cycle 0: reads cycles 1..N_BINS, writes cycles 3..N_BINS+2, done=1 at cycle N_BINS+3.
REQ-025 busy SHALL be 1 in READ and DRAIN, 0 in IDLE and DONE.
REQ-026 Exactly N_BINS writes per completed frame, no gaps, ascending address.
REQ-027 Running peak SHALL be tracked per write; strictly greater replaces; ties keep lower bin; running peak cleared to (0,0) on entering READ.
REQ-028 peak_val/peak_bin SHALL update only on entering DONE and be stable while done=1.
REQ-029 frame_cnt SHALL increment on entering DONE, wrapping 0xFFFF->0x0000.
REQ-030 abort=1 in READ or DRAIN SHALL force IDLE next cycle, clear pipeline valids (no further wr_en), suppress done, leave peak_val, peak_bin, frame_cnt unchanged.
REQ-031 abort in IDLE or DONE SHALL have no effect; start and abort together in IDLE SHALL leave the block in IDLE.
REQ-032 start=1 on the DONE cycle SHALL be ignored; a new frame requires start in IDLE.
REQ-033 Log-magnitude arithmetic SHALL be full precision: 32-bit squares, 33-bit sum, no intermediate truncation.

Reset
REQ-034 rst_n=0 SHALL asynchronously force IDLE, rd_en=0, rd_addr=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, peak_val=0, peak_bin=0, frame_cnt=0, pipeline valids=0.
REQ-035 Reset mid-frame SHALL drop the frame; no write SHALL occur in the cycle after reset release.

Structure
REQ-036 State encoding and the bin-word field positions (x high, y low) SHALL live in a shared package, spectrum_pkg.
REQ-037 The magnitude-to-log computation SHALL be one instantiated sub-module, log_mag_calc, between stage 1 and stage 2.

Verification
REQ-038 N_BINS=4, bins x=1,2,4,8, y=0, start at cycle 0 -> writes addr 0..3 at cycles 3..6 with reference-model values; done at cycle 7; frame_cnt=1.
REQ-039 Equal maxima at bins 1 and 3 -> peak_bin=1; peak_val equals bin 1 value.
REQ-040 abort at cycle 3 of an N_BINS=8 frame -> no wr_en from cycle 4; no done; frame_cnt and peak unchanged; a later start runs a full frame.
REQ-041 start pulsed during READ and on the DONE cycle -> ignored; exactly one frame of N_BINS writes.
REQ-042 frame_cnt preset via 65535 frames (or forced) -> next done wraps frame_cnt to 0.
REQ-043 rst_n asserted mid-READ -> all outputs zero immediately; no wr_en after release until a new start.
